// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmit path.
package ps2_pkg;

  // Host transmit sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_t;

  // Positions inside the shifted frame (data occupies bits 7..0).
  localparam int PS2_PARITY_IDX = 8;
  localparam int PS2_STOP_IDX   = 9;

  // Build the 11-bit frame: data LSB first, odd parity, stop bit, and a
  // trailing released slot that is never driven low.
  function automatic logic [10:0] ps2_build_frame(input logic [7:0] data);
    logic [10:0] f;
    f                 = '1;
    f[7:0]            = data;
    f[PS2_PARITY_IDX] = ~^data;
    f[PS2_STOP_IDX]   = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a group of PS/2 pad inputs, with a registered
// falling-edge detector on bit 0 (the clock line). Other bits are only
// synchronized.
module ps2_sync_edge #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] sync_out,
  output logic             fe
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;
  logic             prev_q, prev_d;
  logic             fe_q, fe_d;

  // Next-state: shift pads through the synchronizer and flag a 1->0 step of bit 0.
  always_comb begin
    meta_d = pad_in;
    sync_d = meta_q;
    prev_d = sync_q[0];
    fe_d   = prev_q & ~sync_q[0];
  end

  // Registers; idle PS/2 lines are high, so the chain resets to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
      prev_q <= 1'b1;
      fe_q   <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      fe_q   <= fe_d;
    end
  end

  assign sync_out = sync_q;
  assign fe       = fe_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts one command byte out on device-generated clocks and checks the ack.
// The pads are driven by the parent as kclk = ps2_clk_oe ? 1'b0 : 1'bz.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6500,
  parameter int TIMEOUT_CYCLES = 1_300_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       STOP_CNT     = 4'(PS2_STOP_IDX);

  ps2_tx_state_t    state_q, state_d;
  logic [10:0]      frame_q, frame_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [1:0]       pad_sync;
  logic             clk_sync;
  logic             data_sync;
  logic             clk_fe;

  ps2_sync_edge #(
    .WIDTH(2)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .pad_in  ({ps2_data_in, ps2_clk_in}),
    .sync_out(pad_sync),
    .fe      (clk_fe)
  );

  assign clk_sync  = pad_sync[0];
  assign data_sync = pad_sync[1];

  // Sequencer: next state, frame shifting, shared inhibit/timeout counter and line drives.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bitcnt_d  = bitcnt_q;
    cnt_d     = cnt_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        cnt_d     = '0;
        bitcnt_d  = '0;
        if (tx_valid && tx_ready) begin
          frame_d  = ps2_build_frame(tx_data);
          clk_oe_d = 1'b1;
          state_d  = INHIBIT;
        end
      end

      INHIBIT: begin
        clk_oe_d  = 1'b1;
        data_oe_d = 1'b0;
        if (cnt_q == INHIBIT_LAST) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      REQ: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b1;
        bitcnt_d  = '0;
        cnt_d     = '0;
        state_d   = SEND;
      end

      SEND: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == TIMEOUT_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = IDLE;
        end else if (clk_fe) begin
          data_oe_d = ~frame_q[bitcnt_q];
          bitcnt_d  = bitcnt_q + 4'd1;
          if (bitcnt_q == STOP_CNT) begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end
        end
      end

      ACK: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (clk_fe) begin
          if (!data_sync) begin
            state_d = WAIT_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      WAIT_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (clk_sync && data_sync) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset releases both lines with no status pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      bitcnt_q  <= '0;
      cnt_q     <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bitcnt_q  <= bitcnt_d;
      cnt_q     <= cnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Ready only once the completion pulse has cleared, one cycle after busy drops.
  assign tx_ready    = (state_q == IDLE) && !done_q && !err_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: a PS/2 device model on open-drain lines,
// a vector table of command bytes, and hand-written corner sequences.
module tb_ps2_host_tx;

  localparam int INHIBIT = 20;
  localparam int TIMEOUT = 1000;
  localparam int HALF    = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, busy, done, err;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       devClk, devData;

  int total = 0;
  int bad = 0;
  int doneCount = 0;
  int errCount = 0;

  logic [9:0] recBits;
  logic       recStart;
  bit         recOk;

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         expParity;
    int         expDone;
    int         expErr;
  } vec_t;

  vec_t vecs[6];

  ps2_host_tx #(
    .INHIBIT_CYCLES(INHIBIT),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  // Open-drain wired-AND of host and device drivers on each line.
  assign ps2_clk_in  = ~ps2_clk_oe & devClk;
  assign ps2_data_in = ~ps2_data_oe & devData;

  always #5 clk = ~clk;

  // Count status pulses away from the active edge.
  always @(negedge clk) begin
    if (done) doneCount++;
    if (err) errCount++;
  end

  // Global guard so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = ~d;
  endtask

  // Device model: wait for the request-to-send, then clock out pulses,
  // sampling the data line on each rising edge and optionally acking.
  task automatic deviceClock(input int pulses, input bit ack,
                             output logic [9:0] bits, output logic startBit, output bit ok);
    ok       = 1'b0;
    bits     = '1;
    startBit = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      repeat (5) @(negedge clk);
      startBit = ps2_data_in;
      for (int k = 1; k <= pulses; k++) begin
        if (k == 11 && ack) devData = 1'b0;
        devClk = 1'b0;
        repeat (HALF) @(negedge clk);
        devClk = 1'b1;
        if (k <= 10) bits[k-1] = ps2_data_in;
        repeat (HALF) @(negedge clk);
      end
      devData = 1'b1;
    end
  endtask

  task automatic waitBusyLow();
    int n = 0;
    while (busy === 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("busy_drop", busy, 1'b0);
  endtask

  initial begin
    int d0, e0, hi, k;
    logic lastDataOe, beforeLastDataOe, readyDuring, oeSeen;

    vecs[0] = '{8'hED, 1'b1, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1, 0};
    vecs[2] = '{8'h01, 1'b1, 1'b0, 1, 0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 1, 0};
    vecs[4] = '{8'hF4, 1'b1, 1'b0, 1, 0};
    vecs[5] = '{8'hAA, 1'b0, 1'b1, 0, 1};

    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    devClk   = 1'b1;
    devData  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_clk_oe", ps2_clk_oe, 1'b0);
    checkOutput("rst_data_oe", ps2_data_oe, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_tx_ready", tx_ready, 1'b1);

    // Acceptance timing, inhibit window length, then timeout with a silent device.
    d0 = doneCount;
    e0 = errCount;
    applyStimulus(8'h3C);
    checkOutput("accept_busy", busy, 1'b1);
    checkOutput("accept_clk_oe", ps2_clk_oe, 1'b1);
    checkOutput("accept_tx_ready", tx_ready, 1'b0);
    hi = 0;
    lastDataOe = 1'b0;
    beforeLastDataOe = 1'b1;
    while (ps2_clk_oe === 1'b1 && hi < 100) begin
      if (hi == INHIBIT - 1) beforeLastDataOe = ps2_data_oe;
      lastDataOe = ps2_data_oe;
      hi++;
      @(negedge clk);
    end
    checkOutput("inhibit_len", hi, INHIBIT + 1);
    checkOutput("req_data_oe", lastDataOe, 1'b1);
    checkOutput("inhibit_data_oe", beforeLastDataOe, 1'b0);
    k = 0;
    while (err !== 1'b1 && k < 1500) begin
      @(negedge clk);
      k++;
    end
    checkOutput("timeout_cycles", k, TIMEOUT);
    checkOutput("timeout_busy", busy, 1'b0);
    checkOutput("timeout_clk_oe", ps2_clk_oe, 1'b0);
    checkOutput("timeout_data_oe", ps2_data_oe, 1'b0);
    checkOutput("timeout_ready_low", tx_ready, 1'b0);
    @(negedge clk);
    checkOutput("timeout_ready_high", tx_ready, 1'b1);
    checkOutput("timeout_done_count", doneCount - d0, 0);
    checkOutput("timeout_err_count", errCount - e0, 1);

    // Table of command bytes sent to the device model.
    for (int v = 0; v < 6; v++) begin
      d0 = doneCount;
      e0 = errCount;
      applyStimulus(vecs[v].data);
      deviceClock(11, vecs[v].ack, recBits, recStart, recOk);
      checkOutput("vec_request", recOk, 1'b1);
      waitBusyLow();
      repeat (3) @(negedge clk);
      checkOutput("vec_start", recStart, 1'b0);
      checkOutput("vec_data", recBits[7:0], vecs[v].data);
      checkOutput("vec_parity", recBits[8], vecs[v].expParity);
      checkOutput("vec_stop", recBits[9], 1'b1);
      checkOutput("vec_done", doneCount - d0, vecs[v].expDone);
      checkOutput("vec_err", errCount - e0, vecs[v].expErr);
      checkOutput("vec_clk_oe", ps2_clk_oe, 1'b0);
      checkOutput("vec_data_oe", ps2_data_oe, 1'b0);
      checkOutput("vec_tx_ready", tx_ready, 1'b1);
    end

    // Back-pressure: a second request while busy must not disturb the frame.
    d0 = doneCount;
    e0 = errCount;
    readyDuring = 1'b1;
    applyStimulus(8'hED);
    fork
      deviceClock(11, 1'b1, recBits, recStart, recOk);
      begin
        repeat (120) @(negedge clk);
        tx_data     = 8'hF4;
        tx_valid    = 1'b1;
        readyDuring = tx_ready;
        repeat (4) @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    waitBusyLow();
    checkOutput("bp_ready_while_busy", readyDuring, 1'b0);
    checkOutput("bp_data", recBits[7:0], 8'hED);
    checkOutput("bp_parity", recBits[8], 1'b1);
    oeSeen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (ps2_clk_oe) oeSeen = 1'b1;
    end
    checkOutput("bp_no_second_frame", oeSeen, 1'b0);
    checkOutput("bp_done", doneCount - d0, 1);
    checkOutput("bp_err", errCount - e0, 0);

    // Reset mid-frame after the fifth device clock falling edge.
    d0 = doneCount;
    e0 = errCount;
    applyStimulus(8'hA5);
    deviceClock(5, 1'b0, recBits, recStart, recOk);
    checkOutput("rstmid_request", recOk, 1'b1);
    checkOutput("rstmid_busy_before", busy, 1'b1);
    checkOutput("rstmid_data_oe_before", ps2_data_oe, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstmid_clk_oe", ps2_clk_oe, 1'b0);
    checkOutput("rstmid_data_oe", ps2_data_oe, 1'b0);
    checkOutput("rstmid_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstmid_tx_ready", tx_ready, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("rstmid_no_done", doneCount - d0, 0);
    checkOutput("rstmid_no_err", errCount - e0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter, the sending counterpart of the keyboard receive path. It drives the shared open-drain `kclk`/`kdata` lines to send one command byte to the keyboard, such as 0xED (set LEDs), 0xFF (reset) or 0xF4 (enable). It sits beside the keyboard receiver in `top_vga`. The receiver keeps reading device-to-host traffic; the top level combines this block's open-drain enables into the inout pads.

## Interface
- `INHIBIT_CYCLES`, default 6500: clock-low request hold, 100 µs at 65 MHz.
- `TIMEOUT_CYCLES`, default 1_300_000: 20 ms limit for device clocking and ack after the clock line is released.
- `clk`  in  1  system clock. One clock domain only.
- `rst`  in  1  reset, synchronous, active-high.
- `tx_data`  in  8  command byte.
- `tx_valid`  in  1  request to send `tx_data`.
- `tx_ready`  out  1  high only in IDLE.
- `busy`  out  1  high from acceptance until the frame completes or aborts.
- `done`  out  1  one-cycle pulse: frame acknowledged.
- `err`  out  1  one-cycle pulse: missing ack or timeout.
- `ps2_clk_in`  in  1  raw `kclk` pad value.
- `ps2_data_in`  in  1  raw `kdata` pad value.
- `ps2_clk_oe`  out  1  1 means pull `kclk` low; 0 means release it.
- `ps2_data_oe`  out  1  1 means pull `kdata` low; 0 means release it.

## Operation
- Input conditioning: `ps2_clk_in` and `ps2_data_in` each pass through a 2-flop synchronizer. The falling-edge pulse `fe` is the previous synchronized clock value AND NOT the current one.
- Frame register: 11 bits, LSB first: `tx_data[7:0]`, odd parity (`~^tx_data`), stop bit = 1. A 4-bit counter `bitcnt` selects the bit being presented.
- Handshake: the byte is captured when `tx_valid && tx_ready` at a rising edge. `tx_valid` is ignored whenever `tx_ready` is 0; there is no queue.
- States:
  - IDLE: both oe = 0; `tx_ready` = 1.
  - INHIBIT: `ps2_clk_oe` = 1; counts `INHIBIT_CYCLES` cycles, then goes to REQ.
  - REQ: lasts 1 cycle; both oe = 1, asserting the start bit while the clock is still held. Then goes to SEND with `bitcnt` = 0.
  - SEND: `ps2_clk_oe` = 0.
    - `ps2_data_oe` stays 1 (start bit) until the first `fe`.
    - On each `fe`: `ps2_data_oe` ← ~frame[`bitcnt`] and `bitcnt` increments.
    - After the `fe` that presents the stop bit (`bitcnt` 9→10), go to ACK with `ps2_data_oe` = 0.
  - ACK: both oe = 0. On the next `fe`, sample synchronized data: 0 means ack, go to WAIT_IDLE; 1 means `err`, go to IDLE.
  - WAIT_IDLE: waits until synchronized clock and data are both 1, then pulses `done` and goes to IDLE.
- Timeout: a counter clears on entry to SEND and increments every cycle in SEND, ACK and WAIT_IDLE. Reaching `TIMEOUT_CYCLES` releases both lines, pulses `err` and returns to IDLE.
- Both oe are registered outputs; no combinational path from any input.

## Timing
- Reset values: state = IDLE, `ps2_clk_oe` = 0, `ps2_data_oe` = 0, `busy` = 0, `done` = 0, `err` = 0, `tx_ready` = 1, all counters 0. Synchronizer flops reset to 1.
- Acceptance at edge N: at N+1 `busy` = 1, `ps2_clk_oe` = 1 and `tx_ready` = 0.
- `ps2_clk_oe` stays 1 for exactly `INHIBIT_CYCLES` + 1 cycles (INHIBIT plus REQ).
- Pad fall to `ps2_data_oe` update: 4 cycles (2 sync flops, edge register, output register).
- `done`/`err` pulse on the same cycle `busy` drops. `tx_ready` rises on the following cycle.
- `rst` mid-frame: both lines are released at the next edge and no `done`/`err` pulse is emitted.
- Timeout and `fe` in the same cycle: the timeout wins.

## Structure
- `ps2_pkg` contains:
  - the state enum `ps2_tx_state_t`;
  - the frame index constants `PS2_PARITY_IDX` = 8 and `PS2_STOP_IDX` = 9.
- Sub-module `ps2_sync_edge`: 2-flop synchronizer plus falling-edge detector. Used for the clock line; the data line uses the synchronizer half only.
- Top-level integration: `kclk = ps2_clk_oe ? 1'b0 : 1'bz`, and the same form for `kdata`.

## Test plan
- **Send 0xED** (device model clocks at 12 kHz and acks):
  - bits presented, in order: 1,0,1,1,0,1,1,1;
  - parity bit 1, stop bit 1;
  - one `done` pulse and no `err`.
- **Parity corners**:
  - send 0x00: parity bit 1;
  - send 0x01: parity bit 0;
  - send 0xFF: parity bit 1;
  - each byte recovered correctly by the device model.
- **Inhibit length, parameter overrides**: with `INHIBIT_CYCLES` = 20, `ps2_clk_oe` is high for exactly 21 cycles. `ps2_data_oe` is 1 in the final cycle of that window.
- **Missing ack**: device leaves data high on the 11th falling edge. Expect one `err` pulse, no `done`, both oe = 0.
- **No device clock**: after the clock line is released, `err` pulses exactly `TIMEOUT_CYCLES` cycles later. With override 1000, `err` is seen at cycle 1000.
- **Reset and back-pressure**:
  - a `tx_valid` of 0xF4 while busy is ignored and does not change the frame in progress;
  - `rst` after the 5th falling edge gives oe = 0 on the next cycle and `tx_ready` = 1 afterwards.
